// File: rtl/cipher_pkg.sv
// Shared ASCII class bounds, moduli and helpers for the stream cipher.
// Used by stream_encrypt (optionally built with STREAM_ENCRYPT_ROLLING_KEY_EN) and caesar_shift_enc.
package cipher_pkg;

    localparam logic [7:0] DIGIT_LO = 8'h30;
    localparam logic [7:0] DIGIT_HI = 8'h39;
    localparam logic [7:0] UPPER_LO = 8'h41;
    localparam logic [7:0] UPPER_HI = 8'h5A;
    localparam logic [7:0] LOWER_LO = 8'h61;
    localparam logic [7:0] LOWER_HI = 8'h7A;

    localparam logic [5:0] MOD10 = 6'd10;
    localparam logic [5:0] MOD26 = 6'd26;

    typedef enum logic [1:0] {DIGIT, UPPER, LOWER, OTHER} char_class_e;

    function automatic char_class_e classifyChar(input logic [7:0] c);
        char_class_e cls;
        cls = OTHER;
        if (c >= DIGIT_LO && c <= DIGIT_HI) cls = DIGIT;
        else if (c >= UPPER_LO && c <= UPPER_HI) cls = UPPER;
        else if (c >= LOWER_LO && c <= LOWER_HI) cls = LOWER;
        return cls;
    endfunction

    // Both operands are already below m, so a single conditional subtract reduces the sum.
    function automatic logic [5:0] addMod(input logic [5:0] a, input logic [5:0] b,
                                          input logic [5:0] m);
        logic [5:0] sum;
        sum = a + b;
        return (sum >= m) ? sum - m : sum;
    endfunction

endpackage

// File: rtl/caesar_shift_enc.sv
// Combinational Caesar mapper: rotates digits by k10 and letters by k26 within their class.
// Any byte outside the three classes passes through untouched.
module caesar_shift_enc
    import cipher_pkg::*;
(
    input  logic [7:0] in_char_i,
    input  logic [4:0] k26_i,
    input  logic [3:0] k10_i,
    output logic [7:0] out_char_o
);

    char_class_e charClass;
    logic [7:0]  base;
    logic [5:0]  relPos;
    logic [5:0]  shiftAmt;
    logic [5:0]  modulus;
    logic [5:0]  shiftedPos;

    always_comb begin
        charClass = classifyChar(in_char_i);
        base      = 8'h00;
        shiftAmt  = 6'd0;
        modulus   = MOD26;
        case (charClass)
            DIGIT: begin
                base     = DIGIT_LO;
                shiftAmt = {2'b00, k10_i};
                modulus  = MOD10;
            end
            UPPER: begin
                base     = UPPER_LO;
                shiftAmt = {1'b0, k26_i};
            end
            LOWER: begin
                base     = LOWER_LO;
                shiftAmt = {1'b0, k26_i};
            end
            default: ;
        endcase
        relPos     = 6'(in_char_i - base);
        shiftedPos = addMod(relPos, shiftAmt, modulus);
        out_char_o = (charClass == OTHER) ? in_char_i : base + {2'b00, shiftedPos};
    end

endmodule

// File: rtl/stream_encrypt.sv
// Streaming Caesar encryptor: key registers, encrypt-at-accept, DEPTH-entry output FIFO, char counter.
// Define STREAM_ENCRYPT_ROLLING_KEY_EN to add a per-character rolling offset to the key.
module stream_encrypt
    import cipher_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_load,
    input  logic [7:0]  key_value,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic [15:0] char_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [4:0]  key26_q;
    logic [3:0]  key10_q;
    logic [4:0]  effK26;
    logic [3:0]  effK10;
    logic [7:0]  encChar;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wrPtr_q, wrPtr_d;
    logic [AW:0] rdPtr_q, rdPtr_d;
    logic [7:0]  lastOut_q;
    logic [15:0] count_q, count_d;

    logic full;
    logic empty;
    logic accept;
    logic xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key26_q <= 5'd0;
            key10_q <= 4'd0;
        end else if (key_load) begin
            key26_q <= 5'(key_value % {2'b00, MOD26});
            key10_q <= 4'(key_value % {2'b00, MOD10});
        end
    end

`ifdef STREAM_ENCRYPT_ROLLING_KEY_EN
    logic [4:0] off26_q;
    logic [3:0] off10_q;

    // Offset advances on every accepted character regardless of class, restarting on a new key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off26_q <= 5'd0;
            off10_q <= 4'd0;
        end else if (key_load) begin
            off26_q <= 5'd0;
            off10_q <= 4'd0;
        end else if (accept) begin
            off26_q <= 5'(addMod({1'b0, off26_q}, 6'd1, MOD26));
            off10_q <= 4'(addMod({2'b00, off10_q}, 6'd1, MOD10));
        end
    end

    assign effK26 = 5'(addMod({1'b0, key26_q}, {1'b0, off26_q}, MOD26));
    assign effK10 = 4'(addMod({2'b00, key10_q}, {2'b00, off10_q}, MOD10));
`else
    assign effK26 = key26_q;
    assign effK10 = key10_q;
`endif

    caesar_shift_enc u_mapper (
        .in_char_i  (in_data),
        .k26_i      (effK26),
        .k10_i      (effK10),
        .out_char_o (encChar)
    );

    assign empty    = (wrPtr_q == rdPtr_q);
    assign full     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign in_ready = !full && !key_load;
    assign accept   = in_valid && in_ready;
    assign out_valid = !empty;
    assign xfer     = out_valid && out_ready;

    // When empty the output shows the last byte handed over, not a stale FIFO slot.
    assign out_data   = empty ? lastOut_q : mem[rdPtr_q[AW-1:0]];
    assign char_count = count_q;

    always_comb begin
        wrPtr_d = accept ? wrPtr_q + PTR_ONE : wrPtr_q;
        rdPtr_d = xfer ? rdPtr_q + PTR_ONE : rdPtr_q;
        count_d = accept ? count_q + 16'd1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wrPtr_q[AW-1:0]] <= encChar;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            lastOut_q <= 8'h00;
            count_q   <= 16'd0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (xfer) lastOut_q <= out_data;
        end
    end

endmodule

// File: doc/stream_encrypt.md
STREAM_ENCRYPT -- requirements
Module: stream_encrypt

Interface
REQ-001 Parameter: DEPTH, 4, number of entries in the output buffer (power of two, >=2).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: key_load  input  1  one-cycle strobe that captures key_value as the new shift.
REQ-005 Port: key_value  input  8  shift amount, unsigned 0-255.
REQ-006 Port: in_valid  input  1  plaintext character present.
REQ-007 Port: in_data  input  8  plaintext ASCII character.
REQ-008 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port: out_valid  output  1  ciphertext character present.
REQ-010 Port: out_data  output  8  ciphertext ASCII character.
REQ-011 Port: out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 Port: char_count  output  16  number of characters accepted since reset.

Function
REQ-013 Accept: in_valid && in_ready at a rising edge; transfer: out_valid && out_ready at a rising edge.
REQ-014 Key registers hold shift%26 (5 bits) and shift%10 (4 bits), computed from key_value at the key_load edge; key_value ignored otherwise.
REQ-015 in_ready = !full && !key_load; no character is accepted in a key_load cycle.
REQ-016 Characters accepted after a key_load edge use the new key; characters already buffered keep their ciphertext.
REQ-017 Digits 0x30-0x39: out = 0x30 + ((in-0x30) + k10) mod 10.
REQ-018 Uppercase 0x41-0x5A: out = 0x41 + ((in-0x41) + k26) mod 26; lowercase 0x61-0x7A likewise with base 0x61.
REQ-019 All other byte values pass through unchanged; intermediate sums computed at >=6 bits, no 8-bit overflow.
REQ-020 Encryption is applied at accept; the encrypted byte is written to the DEPTH-entry FIFO.
REQ-021 Latency: a character accepted into an empty FIFO at edge N appears on out_data with out_valid=1 after edge N (one cycle); no combinational in->out path.
REQ-022 out_valid = FIFO not empty; out_data = head entry, stable while out_valid && !out_ready.
REQ-023 Simultaneous accept and transfer: occupancy unchanged, order preserved.
REQ-024 Full: in_ready=0 even if out_ready=1 in that cycle; no overwrite. Empty: out_valid=0, out_data holds last value.
REQ-025 char_count increments by 1 per accept, wraps 0xFFFF->0x0000; not cleared by key_load.

Reset
REQ-026 On rst: FIFO empty, out_valid=0, out_data=0x00, in_ready=1 (after rst deasserts), char_count=0, both key registers=0 (pass-through cipher).
REQ-027 Reset asserted mid-stream discards all buffered characters immediately and asynchronously.

Configuration
REQ-028 Macro STREAM_ENCRYPT_ROLLING_KEY_EN defined: an offset register (mod 26 and mod 10 copies) adds to the key for each character, increments by 1 after every accepted character of any class, and is cleared by key_load and rst.
REQ-029 Macro undefined: no offset register; a fixed Caesar shift per REQ-017/018.

Structure
REQ-030 Shared package cipher_pkg holds ASCII range bounds (0x30/0x39/0x41/0x5A/0x61/0x7A), moduli 10 and 26, and the character-class enum (DIGIT, UPPER, LOWER, OTHER).
REQ-031 The combinational character mapper is a sub-module caesar_shift_enc (in char, k26, k10 -> out char); stream_encrypt holds the key, FIFO, counter and handshake.

Verification
REQ-032 key_value=3; send 'A','z','9' (0x41,0x7A,0x39) -> out 'D','c','2' (0x44,0x63,0x32), first output one cycle after accept.
REQ-033 key_value=29; send 'x','8','!' (0x78,0x38,0x21) -> out 'a','7','!' (0x61,0x37,0x21).
REQ-034 out_ready=0, send 5 chars -> 4 accepted, in_ready=0, char_count=4; raise out_ready -> 4 outputs in order, 5th then accepted.
REQ-035 key_load with in_valid=1 -> in_ready=0 that cycle; next char uses the new key, buffered chars unchanged.
REQ-036 Assert rst with 3 chars buffered -> out_valid=0, char_count=0 immediately; after release, 'B' passes through unchanged.
REQ-037 ROLLING_KEY_EN build: key_value=1, send "AAA" -> "BCD"; key_load again -> offset restarts.
